// File: rtl/ram_arb_pkg.sv
//==============================================================================
// Module   : ram_arb_pkg
// Brief    : Shared types and opcodes for the RAM command arbiter.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package ram_arb_pkg;

    localparam int CMD_W = 10;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_RCMD  = 3'd3,
        ST_RWAIT = 3'd4
    } state_t;

    function automatic int rr_wrap(input int base, input int offset, input int modulo);
        return (base + offset) % modulo;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arb_rr_picker.sv
//==============================================================================
// Module   : ram_arb_rr_picker
// Brief    : Combinational round-robin select: first request at or after rr_ptr.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module ram_arb_rr_picker
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_any
);

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (req[rr_wrap(int'(rr_ptr), off, NUM_REQ)]) begin
                grant = '0;
                grant[rr_wrap(int'(rr_ptr), off, NUM_REQ)] = 1'b1;
                grant_idx = PTR_W'(rr_wrap(int'(rr_ptr), off, NUM_REQ));
                grant_any = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_cmd_arbiter.sv
//==============================================================================
// Module   : ram_cmd_arbiter
// Brief    : Round-robin sharing of the RAM 10-bit command port among requesters.
//            Optional RAM_ARB_ADDR_SKIP_EN skips redundant address commands.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module ram_cmd_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [CMD_W-1:0]          ram_din,
    output logic                      ram_rx_valid,
    input  logic [DATA_W-1:0]         ram_dout,
    input  logic                      ram_tx_valid
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state;
    state_t              state_nxt;
    logic [PTR_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0]  grant;
    logic [PTR_W-1:0]    grant_idx;
    logic                grant_any;
    logic                handshake;
    logic                skip_addr;

    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                cur_we;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_wdata;
    logic [PTR_W-1:0]    cur_idx;
    logic                op_we;
    logic [ADDR_W-1:0]   op_addr;
    logic [DATA_W-1:0]   op_wdata;

    logic [CMD_W-1:0]    din_nxt;
    logic                rx_valid_nxt;
    logic                read_done;
    logic [NUM_REQ-1:0]  rsp_valid_nxt;
    logic [DATA_W-1:0]   rsp_rdata_nxt;

    ram_arb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = (state == ST_IDLE) ? grant : '0;
    assign handshake = (state == ST_IDLE) && grant_any;

    assign sel_we    = req_we[grant_idx];
    assign sel_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];

    // In IDLE the command for the next cycle comes straight from the winner's inputs.
    assign op_we    = (state == ST_IDLE) ? sel_we    : cur_we;
    assign op_addr  = (state == ST_IDLE) ? sel_addr  : cur_addr;
    assign op_wdata = (state == ST_IDLE) ? sel_wdata : cur_wdata;

`ifdef RAM_ARB_ADDR_SKIP_EN
    logic [ADDR_W-1:0] wr_mirror;
    logic [ADDR_W-1:0] rd_mirror;
    logic              wr_mirror_vld;
    logic              rd_mirror_vld;

    assign skip_addr = sel_we ? (wr_mirror_vld && (wr_mirror == sel_addr))
                              : (rd_mirror_vld && (rd_mirror == sel_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_mirror     <= '0;
            rd_mirror     <= '0;
            wr_mirror_vld <= 1'b0;
            rd_mirror_vld <= 1'b0;
        end else if (handshake && !skip_addr) begin
            if (sel_we) begin
                wr_mirror     <= sel_addr;
                wr_mirror_vld <= 1'b1;
            end else begin
                rd_mirror     <= sel_addr;
                rd_mirror_vld <= 1'b1;
            end
        end
    end
`else
    assign skip_addr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (handshake) begin
                    if (skip_addr) begin
                        state_nxt = sel_we ? ST_WDATA : ST_RCMD;
                    end else begin
                        state_nxt = ST_ADDR;
                    end
                end
            end
            ST_ADDR:  state_nxt = cur_we ? ST_WDATA : ST_RCMD;
            ST_WDATA: state_nxt = ST_IDLE;
            ST_RCMD:  state_nxt = ST_RWAIT;
            ST_RWAIT: state_nxt = ram_tx_valid ? ST_IDLE : ST_RWAIT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered, so decode against the state being entered.
    always_comb begin
        din_nxt       = '0;
        rx_valid_nxt  = 1'b0;
        read_done     = (state == ST_RWAIT) && ram_tx_valid;
        rsp_valid_nxt = '0;
        rsp_rdata_nxt = '0;
        case (state_nxt)
            ST_ADDR: begin
                din_nxt      = {(op_we ? OP_WR_ADDR : OP_RD_ADDR), op_addr};
                rx_valid_nxt = 1'b1;
            end
            ST_WDATA: begin
                din_nxt      = {OP_WR_DATA, op_wdata};
                rx_valid_nxt = 1'b1;
            end
            ST_RCMD: begin
                din_nxt      = {OP_RD_DATA, 8'h00};
                rx_valid_nxt = 1'b1;
            end
            default: ;
        endcase
        if ((state == ST_WDATA) || read_done) begin
            rsp_valid_nxt = NUM_REQ'(1) << cur_idx;
        end
        if (read_done) begin
            rsp_rdata_nxt = ram_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
            rsp_valid    <= '0;
            rsp_rdata    <= '0;
        end else begin
            ram_din      <= din_nxt;
            ram_rx_valid <= rx_valid_nxt;
            rsp_valid    <= rsp_valid_nxt;
            rsp_rdata    <= rsp_rdata_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            cur_we    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            cur_idx   <= '0;
        end else if (handshake) begin
            rr_ptr    <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            cur_we    <= sel_we;
            cur_addr  <= sel_addr;
            cur_wdata <= sel_wdata;
            cur_idx   <= grant_idx;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_cmd_arbiter.sv
//==============================================================================
// Module   : tb_ram_cmd_arbiter
// Brief    : Scoreboard bench for ram_cmd_arbiter with a behavioural RAM.
//            Honours RAM_ARB_ADDR_SKIP_EN when compiled with it.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ram_cmd_arbiter;

    localparam int NUM_REQ = 2;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [1:0]   req_we;
    logic [15:0]  req_addr;
    logic [15:0]  req_wdata;
    logic [1:0]   rsp_valid;
    logic [7:0]   rsp_rdata;
    logic [9:0]   ram_din;
    logic         ram_rx_valid;
    logic [7:0]   ram_dout;
    logic         ram_tx_valid;

    typedef struct {int cyc; logic [9:0] din;} cmd_t;
    typedef struct {int cyc; int who; logic [7:0] data;} rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    cmd_t ce;
    rsp_t re;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int stall    = 0;
    int tx_at    = -100;

    logic [7:0] ram_mem [256];
    logic [7:0] sb_mem  [256];
    logic [7:0] ram_wa, ram_ra;

    int         m_rr = 0;
    int         m_idle_from = 0;
    bit         m_rd_wait = 1'b0;
    int         m_rwait_start = 0;
    int         m_rd_who = 0;
    logic [7:0] m_rd_addr;
    bit         m_idle;
    int         g, t;
    bit         skip, hs_we;
    logic [7:0] hs_a, hs_d;
    logic [1:0] exp_ready;
`ifdef RAM_ARB_ADDR_SKIP_EN
    bit         m_wv = 1'b0, m_rv = 1'b0;
    logic [7:0] m_wa, m_ra;
`endif

    ram_cmd_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(8), .DATA_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .ram_din      (ram_din),
        .ram_rx_valid (ram_rx_valid),
        .ram_dout     (ram_dout),
        .ram_tx_valid (ram_tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // RAM read-data driver: answers RD_DATA after the configured stall.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        ram_tx_valid = (cyc == tx_at);
        ram_dout     = ram_tx_valid ? ram_mem[ram_ra] : 8'h00;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            cmd_q.delete();
            rsp_q.delete();
            m_rr        = 0;
            m_idle_from = 0;
            m_rd_wait   = 1'b0;
            tx_at       = -100;
`ifdef RAM_ARB_ADDR_SKIP_EN
            m_wv = 1'b0;
            m_rv = 1'b0;
`endif
            check("reset_out", 32'({req_ready, rsp_valid, rsp_rdata, ram_din, ram_rx_valid}), 32'd0);
        end else begin
            if (ram_rx_valid) begin
                case (ram_din[9:8])
                    2'b00: ram_wa = ram_din[7:0];
                    2'b01: ram_mem[ram_wa] = ram_din[7:0];
                    2'b10: ram_ra = ram_din[7:0];
                    default: tx_at = cyc + 1 + stall;
                endcase
                if (cmd_q.size() > 0) begin
                    ce = cmd_q.pop_front();
                    check("cmd_din", 32'(ram_din), 32'(ce.din));
                    check("cmd_cyc", 32'(cyc), 32'(ce.cyc));
                end else begin
                    check("cmd_unexpected", 32'(ram_rx_valid), 32'd0);
                end
            end
            while (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
                ce = cmd_q.pop_front();
                check("cmd_missing", 32'(cyc), 32'(ce.cyc));
            end
            if (rsp_valid != 2'b00) begin
                if (rsp_q.size() > 0) begin
                    re = rsp_q.pop_front();
                    check("rsp_who", 32'(rsp_valid), 32'(1 << re.who));
                    check("rsp_data", 32'(rsp_rdata), 32'(re.data));
                    check("rsp_cyc", 32'(cyc), 32'(re.cyc));
                end else begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end
            end
            while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
                re = rsp_q.pop_front();
                check("rsp_missing", 32'(cyc), 32'(re.cyc));
            end
            if (m_rd_wait && cyc >= m_rwait_start && ram_tx_valid) begin
                rsp_q.push_back('{cyc + 1, m_rd_who, sb_mem[m_rd_addr]});
                m_idle_from = cyc + 1;
                m_rd_wait   = 1'b0;
            end
            // Reference arbitration: first requester at or after the pointer.
            m_idle    = !m_rd_wait && (cyc >= m_idle_from);
            g         = -1;
            exp_ready = 2'b00;
            if (m_idle) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (g < 0 && req_valid[(m_rr + k) % NUM_REQ]) g = (m_rr + k) % NUM_REQ;
                end
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            if (g >= 0) begin
                hs_we = req_we[g];
                hs_a  = req_addr[g*8 +: 8];
                hs_d  = req_wdata[g*8 +: 8];
                m_rr  = (g + 1) % NUM_REQ;
                skip  = 1'b0;
`ifdef RAM_ARB_ADDR_SKIP_EN
                if (hs_we) begin
                    skip = m_wv && (m_wa == hs_a);
                    if (!skip) begin m_wv = 1'b1; m_wa = hs_a; end
                end else begin
                    skip = m_rv && (m_ra == hs_a);
                    if (!skip) begin m_rv = 1'b1; m_ra = hs_a; end
                end
`endif
                t = cyc + 1;
                if (hs_we) begin
                    if (!skip) begin cmd_q.push_back('{t, {2'b00, hs_a}}); t++; end
                    cmd_q.push_back('{t, {2'b01, hs_d}});
                    rsp_q.push_back('{t + 1, g, 8'h00});
                    m_idle_from = t + 1;
                    sb_mem[hs_a] = hs_d;
                end else begin
                    if (!skip) begin cmd_q.push_back('{t, {2'b10, hs_a}}); t++; end
                    cmd_q.push_back('{t, 10'h300});
                    m_rd_wait     = 1'b1;
                    m_rwait_start = t + 1;
                    m_rd_addr     = hs_a;
                    m_rd_who      = g;
                end
            end
        end
    end

    task automatic do_req(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
        bit done = 1'b0;
        req_valid[i]        = 1'b1;
        req_we[i]           = we;
        req_addr[i*8 +: 8]  = a;
        req_wdata[i*8 +: 8] = d;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                done = 1'b1;
                break;
            end
        end
        check("handshake_timeout", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cmd_q.size() == 0 && rsp_q.size() == 0 && !m_rd_wait) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'h00;
            sb_mem[i]  = 8'h00;
        end
        ram_wa       = 8'h00;
        ram_ra       = 8'h00;
        rst_n        = 1'b0;
        req_valid    = '0;
        req_we       = '0;
        req_addr     = '0;
        req_wdata    = '0;
        ram_tx_valid = 1'b0;
        ram_dout     = 8'h00;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset while the read command is on the bus.
        do_req(1, 1'b0, 8'h3C, 8'h00);
        @(posedge clk);
        #1;
        check("rcmd_din", 32'(ram_din), 32'h300);
        check("rcmd_rx_valid", 32'(ram_rx_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 32'({ram_rx_valid, rsp_valid}), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        do_req(0, 1'b1, 8'h3C, 8'hA5);
        wait_idle();
        do_req(1, 1'b0, 8'h3C, 8'h00);
        wait_idle();

        fork
            begin
                for (int k = 0; k < 4; k++) do_req(0, 1'b1, 8'h40 + 8'(k), 8'h50 + 8'(k));
            end
            begin
                for (int k = 0; k < 4; k++) do_req(1, 1'b0, 8'h40 + 8'(k), 8'h00);
            end
        join
        wait_idle();

        stall = 5;
        do_req(0, 1'b0, 8'h3C, 8'h00);
        wait_idle();
        stall = 0;

        do_req(0, 1'b1, 8'h10, 8'h11);
        wait_idle();
        do_req(1, 1'b1, 8'h10, 8'h22);
        wait_idle();
        do_req(0, 1'b1, 8'h11, 8'h33);
        wait_idle();
        do_req(1, 1'b0, 8'h10, 8'h00);
        wait_idle();
        do_req(0, 1'b0, 8'h10, 8'h00);
        wait_idle();

        repeat (4) @(posedge clk);
        #1;
        check("sb_drain", 32'(cmd_q.size() + rsp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
